// File: rtl/rf_wb_arb_pkg.sv
// Shared constants and the deferred-write entry type for the RF write-back arbiter.
package rf_wb_arb_pkg;
  localparam int DEPTH_DEF        = 2;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int RA_W             = 5;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wa;
    logic [31:0]     wd;
    logic [31:0]     pc;
  } wr_entry_t;
endpackage

// File: rtl/rf_wb_arb_fifo.sv
// Deferred-write FIFO: wrap-around pointers plus count, per-entry cancel by
// register address, and a busy vector of still-valid queued destinations.
module rf_wb_arb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  wr_entry_t       push_ent,
  input  logic            pop,
  input  logic            cancel_en,
  input  logic [RA_W-1:0] cancel_wa,
  output wr_entry_t       head,
  output logic [CW-1:0]   count,
  output logic [31:0]     busy
);
  wr_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           busy_v;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cancel_en && mem_q[i].wa == cancel_wa) mem_d[i].valid = 1'b0;
      if (pop && rd_q == PW'(i))                 mem_d[i].valid = 1'b0;
      if (push && wr_q == PW'(i))                mem_d[i]       = push_ent;
    end
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Popped and cancelled slots have valid cleared, so valid alone marks pending writes.
  always_comb begin
    busy_v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem_q[i].valid) busy_v[mem_q[i].wa] = 1'b1;
    busy = busy_v & ~32'h1;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/rf_wb_arb.sv
// Single RF write-port arbiter: W-stage writes win, multicycle writes are bypassed
// or deferred in a FIFO. Define RF_WB_ARB_TRACE_EN to log every non-$0 RF write.
module rf_wb_arb
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_we,
  input  logic [RA_W-1:0] p_wa,
  input  logic [31:0]     p_wd,
  input  logic [31:0]     p_pc,
  input  logic            m_valid,
  input  logic [RA_W-1:0] m_wa,
  input  logic [31:0]     m_wd,
  input  logic [31:0]     m_pc,
  output logic            m_ready,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic [31:0]     rf_wd,
  output logic [31:0]     rf_pc,
  output logic [31:0]     busy,
  output logic            stall_req
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  wr_entry_t     head, push_ent;
  logic [CW-1:0] count;
  logic [31:0]   fifo_busy;
  logic          push, pop, cancel_en, accept, m_drop, bypass;
  logic          head_live, head_dead, head_kill;
  logic [AW-1:0] age_q, age_d;

  assign head_live = (count != '0) &&  head.valid;
  assign head_dead = (count != '0) && !head.valid;
  assign m_ready   = reset && (count < CW'(DEPTH));
  assign accept    = m_valid && m_ready;
  assign m_drop    = (m_wa == '0) || (p_we && m_wa == p_wa);
  assign cancel_en = reset && p_we && (p_wa != '0);
  assign head_kill = cancel_en && head_live && (head.wa == p_wa);
  assign push_ent  = '{valid: 1'b1, wa: m_wa, wd: m_wd, pc: m_pc};

  always_comb begin
    rf_we  = 1'b0;
    rf_wa  = '0;
    rf_wd  = '0;
    rf_pc  = '0;
    pop    = 1'b0;
    bypass = 1'b0;
    if (reset) begin
      if (p_we) begin
        {rf_we, rf_wa, rf_wd, rf_pc} = {1'b1, p_wa, p_wd, p_pc};
        pop = head_dead;
      end else if (head_live) begin
        {rf_we, rf_wa, rf_wd, rf_pc} = {1'b1, head.wa, head.wd, head.pc};
        pop = 1'b1;
      end else if (head_dead) begin
        pop = 1'b1;
      end else if (accept && !m_drop) begin
        {rf_we, rf_wa, rf_wd, rf_pc} = {1'b1, m_wa, m_wd, m_pc};
        bypass = 1'b1;
      end
    end
    push = accept && !m_drop && !bypass;
  end

  // Age tracks how long the current valid head has been held off by W-stage writes.
  always_comb begin
    age_d = age_q;
    if (!head_live || pop || head_kill) age_d = '0;
    else if (age_q != AW'(STARVE_LIMIT)) age_d = age_q + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end

  assign stall_req = reset && (age_q == AW'(STARVE_LIMIT));
  assign busy      = reset ? fifo_busy : '0;

  rf_wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_ent  (push_ent),
    .pop       (pop),
    .cancel_en (cancel_en),
    .cancel_wa (p_wa),
    .head      (head),
    .count     (count),
    .busy      (fifo_busy)
  );

`ifdef RF_WB_ARB_TRACE_EN
  always @(posedge clk) begin
    if (rf_we && rf_wa != '0)
      $display("%d@%h: $%d <= %h", $time, rf_pc, rf_wa, rf_wd);
  end
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: queue-based reference model checked every cycle plus directed scenarios.
module tb_rf_wb_arb;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        p_we = 1'b0, m_valid = 1'b0;
  logic [4:0]  p_wa = '0, m_wa = '0;
  logic [31:0] p_wd = '0, p_pc = '0, m_wd = '0, m_pc = '0;
  logic        m_ready, rf_we, stall_req;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_pc, busy;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  rf_wb_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc), .m_ready(m_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending deferred writes as a queue, head at index 0.
  typedef struct {
    bit          v;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } ment_t;
  ment_t mq[$];
  ment_t ne;
  int    mage = 0;

  always @(negedge clk) begin
    logic        ewe, erdy, estall;
    logic [4:0]  ewa;
    logic [31:0] ewd, epc, ebusy;
    bit          acc, mdrop, popm, pushm, killh, headwait;
    ewe = 0; ewa = '0; ewd = '0; epc = '0; ebusy = '0;
    popm = 0; pushm = 0; killh = 0;
    erdy   = reset && (mq.size() < DEPTH);
    estall = reset && (mage == LIMIT);
    if (reset) foreach (mq[i]) if (mq[i].v && mq[i].wa != 0) ebusy[mq[i].wa] = 1'b1;
    acc   = m_valid && erdy;
    mdrop = (m_wa == 0) || (p_we && m_wa == p_wa);
    if (reset) begin
      if (p_we) begin
        ewe = 1; ewa = p_wa; ewd = p_wd; epc = p_pc;
        popm  = mq.size() > 0 && !mq[0].v;
        killh = mq.size() > 0 && mq[0].v && p_wa != 0 && mq[0].wa == p_wa;
      end else if (mq.size() > 0) begin
        popm = 1;
        if (mq[0].v) begin ewe = 1; ewa = mq[0].wa; ewd = mq[0].wd; epc = mq[0].pc; end
      end else if (acc && !mdrop) begin
        ewe = 1; ewa = m_wa; ewd = m_wd; epc = m_pc;
      end
      pushm = acc && !mdrop && (p_we || mq.size() > 0);
    end
    if (chk_en) begin
      chk("m_rf_we", {31'b0, rf_we}, {31'b0, ewe});
      chk("m_m_ready", {31'b0, m_ready}, {31'b0, erdy});
      chk("m_stall", {31'b0, stall_req}, {31'b0, estall});
      chk("m_busy", busy, ebusy);
      if (ewe || !reset) begin
        chk("m_rf_wa", {27'b0, rf_wa}, {27'b0, ewa});
        chk("m_rf_wd", rf_wd, ewd);
        chk("m_rf_pc", rf_pc, epc);
      end
    end
    if (!reset) begin
      mq.delete();
      mage = 0;
    end else begin
      headwait = mq.size() > 0 && mq[0].v && !popm && !killh;
      if (popm) void'(mq.pop_front());
      if (p_we && p_wa != 0) foreach (mq[i]) if (mq[i].wa == p_wa) mq[i].v = 0;
      if (pushm) begin
        ne.v = 1; ne.wa = m_wa; ne.wd = m_wd; ne.pc = m_pc;
        mq.push_back(ne);
      end
      mage = headwait ? ((mage < LIMIT) ? mage + 1 : LIMIT) : 0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic pset(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    p_we = we; p_wa = wa; p_wd = wd; p_pc = 32'h1000 + wd;
  endtask
  task automatic mset(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    m_valid = v; m_wa = wa; m_wd = wd; m_pc = 32'h2000 + wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    chk_en = 1;
    mid();
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_m_ready", {31'b0, m_ready}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Bypass on empty FIFO
    mset(1, 5'd5, 32'hA5);
    mid();
    chk("byp_we", {31'b0, rf_we}, 32'd1);
    chk("byp_wa", {27'b0, rf_wa}, 32'd5);
    chk("byp_wd", rf_wd, 32'hA5);
    tick();
    mset(0, 0, 0);
    mid();
    chk("byp_cnt0", {31'b0, m_ready}, 32'd1);
    chk("byp_no_pop", {31'b0, rf_we}, 32'd0);
    tick();

    // P priority, fill to full, then drain in order
    pset(1, 5'd1, 32'h01);
    mset(1, 5'd3, 32'h33);
    mid();
    chk("pri_wa", {27'b0, rf_wa}, 32'd1);
    tick();
    mset(1, 5'd4, 32'h44);
    mid();
    chk("fill_rdy1", {31'b0, m_ready}, 32'd1);
    tick();
    mset(0, 0, 0);
    mid();
    chk("full_rdy0", {31'b0, m_ready}, 32'd0);
    chk("full_busy", busy, 32'h18);
    tick();
    pset(0, 0, 0);
    mid();
    chk("drain1_wa", {27'b0, rf_wa}, 32'd3);
    chk("drain1_wd", rf_wd, 32'h33);
    chk("fullpop_rdy0", {31'b0, m_ready}, 32'd0);
    tick();
    mid();
    chk("drain2_wa", {27'b0, rf_wa}, 32'd4);
    chk("drain2_wd", rf_wd, 32'h44);
    tick();
    mid();
    chk("drained_we", {31'b0, rf_we}, 32'd0);
    tick();

    // WAW cancel of a queued $7
    pset(1, 5'd1, 32'h01);
    mset(1, 5'd7, 32'h11);
    tick();
    mset(0, 0, 0);
    pset(1, 5'd7, 32'h22);
    mid();
    chk("waw_busy_pre", busy, 32'h80);
    chk("waw_p_wd", rf_wd, 32'h22);
    tick();
    pset(0, 0, 0);
    mid();
    chk("waw_busy_post", busy, 32'h0);
    chk("waw_discard_we", {31'b0, rf_we}, 32'd0);
    tick();
    mid();
    chk("waw_after_we", {31'b0, rf_we}, 32'd0);
    tick();

    // Starvation: hold P writes, watch stall_req rise after 8 cycles and saturate
    pset(1, 5'd1, 32'h01);
    mset(1, 5'd6, 32'h66);
    tick();
    mset(0, 0, 0);
    for (int j = 0; j <= 10; j++) begin
      if (j == 10) pset(0, 0, 0);
      mid();
      chk($sformatf("stall_j%0d", j), {31'b0, stall_req}, {31'b0, (j >= 8)});
      if (j == 10) chk("starve_pop_wa", {27'b0, rf_wa}, 32'd6);
      tick();
    end
    mid();
    chk("starve_clr", {31'b0, stall_req}, 32'd0);
    chk("starve_we0", {31'b0, rf_we}, 32'd0);
    tick();

    // Mid-stream reset discards queued writes
    pset(1, 5'd1, 32'h01);
    mset(1, 5'd10, 32'hAA);
    tick();
    mset(1, 5'd11, 32'hBB);
    tick();
    mset(0, 0, 0);
    pset(1, 5'd2, 32'h02);
    reset = 1'b0;
    mid();
    chk("mrst_we", {31'b0, rf_we}, 32'd0);
    chk("mrst_wa", {27'b0, rf_wa}, 32'd0);
    chk("mrst_busy", busy, 32'd0);
    chk("mrst_rdy", {31'b0, m_ready}, 32'd0);
    tick();
    reset = 1'b1;
    pset(0, 0, 0);
    mid();
    chk("post_rst_we", {31'b0, rf_we}, 32'd0);
    chk("post_rst_busy", busy, 32'd0);
    chk("post_rst_rdy", {31'b0, m_ready}, 32'd1);
    tick();

    // $0 requests and same-address M requests are accepted and dropped
    mset(1, 5'd0, 32'hDEAD);
    mid();
    chk("z_rdy", {31'b0, m_ready}, 32'd1);
    chk("z_we", {31'b0, rf_we}, 32'd0);
    tick();
    mset(0, 0, 0);
    mid();
    chk("z_rdy_after", {31'b0, m_ready}, 32'd1);
    chk("z_busy", busy, 32'd0);
    tick();
    pset(1, 5'd8, 32'h80);
    mset(1, 5'd8, 32'h88);
    mid();
    chk("same_wd", rf_wd, 32'h80);
    tick();
    pset(0, 0, 0);
    mset(0, 0, 0);
    mid();
    chk("same_busy", busy, 32'd0);
    chk("same_we", {31'b0, rf_we}, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
